// File: rtl/wb_arbiter_w.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port, ownership held for a whole CYC.
// Define WB_ARB_TIMEOUT_EN to compile in the stall watchdog that aborts a stuck transfer with ERR.
module wb_arbiter_w #(
   parameter int unsigned NUM_MASTERS    = 2,
   parameter int unsigned WB_ADDR_WIDTH  = 32,
   parameter int unsigned WB_DATA_WIDTH  = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]     m_ADR,
   input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]     m_DAT_W,
   input  logic [NUM_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_SEL,
   input  logic [NUM_MASTERS-1:0]                   m_WE,
   input  logic [NUM_MASTERS*3-1:0]                 m_CTI,
   input  logic [NUM_MASTERS*2-1:0]                 m_BTE,
   input  logic [NUM_MASTERS-1:0]                   m_CYC,
   input  logic [NUM_MASTERS-1:0]                   m_STB,
   output logic [WB_DATA_WIDTH-1:0]                 m_DAT_R,
   output logic [NUM_MASTERS-1:0]                   m_ACK,
   output logic [NUM_MASTERS-1:0]                   m_ERR,
   output logic [WB_ADDR_WIDTH-1:0]                 s_ADR,
   output logic [WB_DATA_WIDTH-1:0]                 s_DAT_W,
   output logic [WB_DATA_WIDTH/8-1:0]               s_SEL,
   output logic                                     s_WE,
   output logic [2:0]                               s_CTI,
   output logic [1:0]                               s_BTE,
   output logic                                     s_CYC,
   output logic                                     s_STB,
   input  logic [WB_DATA_WIDTH-1:0]                 s_DAT_R,
   input  logic                                     s_ACK,
   input  logic                                     s_ERR,
   output logic [NUM_MASTERS-1:0]                   gnt
);

   localparam int unsigned SW = WB_DATA_WIDTH / 8;
   localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_masters
      $error("wb_arbiter_w: NUM_MASTERS must be 1..8");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_arbiter_w: TIMEOUT_CYCLES must be 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1
`ifdef WB_ARB_TIMEOUT_EN
      , TERM = 2'd2
`endif
   } state_t;

   state_t                 state, state_n;
   logic [IW-1:0]          owner, owner_n;
   logic [IW-1:0]          last, last_n;
   logic [NUM_MASTERS-1:0] gnt_n;
   logic [IW-1:0]          pick, cand;
   logic                   found;
   logic                   arb;
`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0]            cnt, cnt_n;
`endif

   // Per-master views of the flattened request buses
   logic [WB_ADDR_WIDTH-1:0] adr_a  [NUM_MASTERS];
   logic [WB_DATA_WIDTH-1:0] datw_a [NUM_MASTERS];
   logic [SW-1:0]            sel_a  [NUM_MASTERS];
   logic [2:0]               cti_a  [NUM_MASTERS];
   logic [1:0]               bte_a  [NUM_MASTERS];

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_slice
      assign adr_a[g]  = m_ADR[g*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
      assign datw_a[g] = m_DAT_W[g*WB_DATA_WIDTH +: WB_DATA_WIDTH];
      assign sel_a[g]  = m_SEL[g*SW +: SW];
      assign cti_a[g]  = m_CTI[g*3 +: 3];
      assign bte_a[g]  = m_BTE[g*2 +: 2];
   end

   assign m_DAT_R = s_DAT_R;

   // Round-robin scan starting just after the last winner
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
         cand = IW'((32'(last) + i) % NUM_MASTERS);
         if (!found && m_CYC[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state and slave/master steering
   always_comb begin
      state_n = state;
      owner_n = owner;
      last_n  = last;
      gnt_n   = gnt;
      arb     = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_n   = '0;
`endif
      s_ADR   = '0;
      s_DAT_W = '0;
      s_SEL   = '0;
      s_WE    = 1'b0;
      s_CTI   = '0;
      s_BTE   = '0;
      s_CYC   = 1'b0;
      s_STB   = 1'b0;
      m_ACK   = '0;
      m_ERR   = '0;

      if (state != IDLE) begin
         s_ADR   = adr_a[owner];
         s_DAT_W = datw_a[owner];
         s_SEL   = sel_a[owner];
         s_WE    = m_WE[owner];
         s_CTI   = cti_a[owner];
         s_BTE   = bte_a[owner];
      end

      case (state)
         IDLE: arb = 1'b1;
         OWN: begin
            s_CYC        = m_CYC[owner];
            s_STB        = m_STB[owner] & m_CYC[owner];
            m_ACK[owner] = s_ACK;
            m_ERR[owner] = s_ERR;
            if (!m_CYC[owner]) begin
               arb = 1'b1;
            end
`ifdef WB_ARB_TIMEOUT_EN
            else if (s_STB && !s_ACK && !s_ERR) begin
               if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                  state_n = TERM;
               end else begin
                  cnt_n = cnt + 16'd1;
               end
            end
`endif
         end
`ifdef WB_ARB_TIMEOUT_EN
         // One-cycle abort: slave sees the cycle withdrawn, owner sees ERR
         TERM: begin
            m_ERR[owner] = 1'b1;
            if (!m_CYC[owner]) begin
               arb = 1'b1;
            end else begin
               state_n = OWN;
            end
         end
`endif
         default: state_n = IDLE;
      endcase

      if (arb) begin
         if (found) begin
            state_n = OWN;
            owner_n = pick;
            last_n  = pick;
            gnt_n   = NUM_MASTERS'(1) << pick;
         end else begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         owner <= '0;
         last  <= IW'(NUM_MASTERS - 1);
         gnt   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
         cnt   <= '0;
`endif
      end else begin
         state <= state_n;
         owner <= owner_n;
         last  <= last_n;
         gnt   <= gnt_n;
`ifdef WB_ARB_TIMEOUT_EN
         cnt   <= cnt_n;
`endif
      end
   end

endmodule

// File: tb/tb_wb_arbiter_w.sv
// Self-checking bench for wb_arbiter_w: directed scenarios plus randomized traffic against a bus-ownership model.
module tb_wb_arbiter_w;

   localparam int unsigned N  = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;
`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned TMO  = 8;
   localparam bit          WDOG = 1'b1;
`else
   localparam int unsigned TMO  = 255;
   localparam bit          WDOG = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   logic [AW-1:0] adr  [N];
   logic [DW-1:0] datw [N];
   logic [SW-1:0] sel  [N];
   logic          we   [N];
   logic [2:0]    cti  [N];
   logic [1:0]    bte  [N];
   logic          cyc  [N];
   logic          stb  [N];

   logic [N*AW-1:0] m_ADR;
   logic [N*DW-1:0] m_DAT_W;
   logic [N*SW-1:0] m_SEL;
   logic [N-1:0]    m_WE, m_CYC, m_STB, m_ACK, m_ERR, gnt;
   logic [N*3-1:0]  m_CTI;
   logic [N*2-1:0]  m_BTE;
   logic [DW-1:0]   m_DAT_R, s_DAT_W, s_DAT_R;
   logic [AW-1:0]   s_ADR;
   logic [SW-1:0]   s_SEL;
   logic            s_WE, s_CYC, s_STB, s_ACK, s_ERR;
   logic [2:0]      s_CTI;
   logic [1:0]      s_BTE;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: who owns the bus, who won last, abort flag, consecutive stalled cycles
   int own   = -1;
   int last  = N - 1;
   bit term  = 1'b0;
   int stall = 0;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         m_ADR[i*AW +: AW]   = adr[i];
         m_DAT_W[i*DW +: DW] = datw[i];
         m_SEL[i*SW +: SW]   = sel[i];
         m_WE[i]             = we[i];
         m_CTI[i*3 +: 3]     = cti[i];
         m_BTE[i*2 +: 2]     = bte[i];
         m_CYC[i]            = cyc[i];
         m_STB[i]            = stb[i];
      end
   end

   wb_arbiter_w #(
      .NUM_MASTERS   (N),
      .WB_ADDR_WIDTH (AW),
      .WB_DATA_WIDTH (DW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .m_ADR  (m_ADR),
      .m_DAT_W(m_DAT_W),
      .m_SEL  (m_SEL),
      .m_WE   (m_WE),
      .m_CTI  (m_CTI),
      .m_BTE  (m_BTE),
      .m_CYC  (m_CYC),
      .m_STB  (m_STB),
      .m_DAT_R(m_DAT_R),
      .m_ACK  (m_ACK),
      .m_ERR  (m_ERR),
      .s_ADR  (s_ADR),
      .s_DAT_W(s_DAT_W),
      .s_SEL  (s_SEL),
      .s_WE   (s_WE),
      .s_CTI  (s_CTI),
      .s_BTE  (s_BTE),
      .s_CYC  (s_CYC),
      .s_STB  (s_STB),
      .s_DAT_R(s_DAT_R),
      .s_ACK  (s_ACK),
      .s_ERR  (s_ERR),
      .gnt    (gnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Ownership model advanced on every clock edge
   always @(posedge clk or posedge rst) begin : model
      int  nown, nlast, nstall;
      bit  nterm, rearb;
      if (rst) begin
         own   <= -1;
         last  <= N - 1;
         term  <= 1'b0;
         stall <= 0;
      end else begin
         nown   = own;
         nlast  = last;
         nstall = 0;
         nterm  = 1'b0;
         rearb  = 1'b0;
         if (own < 0 || !cyc[own]) begin
            rearb = 1'b1;
         end else if (!term && WDOG && stb[own] && !s_ACK && !s_ERR) begin
            nstall = stall + 1;
            if (nstall == int'(TMO)) begin
               nterm  = 1'b1;
               nstall = 0;
            end
         end
         if (rearb) begin
            nown = -1;
            for (int k = 1; k <= N; k++) begin
               if (nown < 0 && cyc[(last + k) % N]) begin
                  nown  = (last + k) % N;
                  nlast = nown;
               end
            end
         end
         own   <= nown;
         last  <= nlast;
         term  <= nterm;
         stall <= nstall;
      end
   end

   // Every cycle: compare all DUT outputs with what the model says they must be
   always @(negedge clk) begin : compare
      logic [N-1:0]  eg, eack, eerr;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [SW-1:0] es;
      logic [2:0]    ect;
      logic [1:0]    ebt;
      logic          ewe, ecyc, estb;
      eg = '0; eack = '0; eerr = '0; ea = '0; ed = '0; es = '0;
      ect = '0; ebt = '0; ewe = 1'b0; ecyc = 1'b0; estb = 1'b0;
      if (own >= 0) begin
         eg[own] = 1'b1;
         ea  = adr[own];
         ed  = datw[own];
         es  = sel[own];
         ewe = we[own];
         ect = cti[own];
         ebt = bte[own];
         if (term) begin
            eerr[own] = 1'b1;
         end else begin
            ecyc      = cyc[own];
            estb      = cyc[own] & stb[own];
            eack[own] = s_ACK;
            eerr[own] = s_ERR;
         end
      end
      chk("gnt", gnt, eg);
      chk("s_ADR", s_ADR, ea);
      chk("s_DAT_W", s_DAT_W, ed);
      chk("s_SEL", s_SEL, es);
      chk("s_WE", s_WE, ewe);
      chk("s_CTI", s_CTI, ect);
      chk("s_BTE", s_BTE, ebt);
      chk("s_CYC", s_CYC, ecyc);
      chk("s_STB", s_STB, estb);
      chk("m_ACK", m_ACK, eack);
      chk("m_ERR", m_ERR, eerr);
      chk("m_DAT_R", m_DAT_R, s_DAT_R);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_all();
      for (int i = 0; i < N; i++) begin
         cyc[i] = 1'b0;
         stb[i] = 1'b0;
      end
      s_ACK = 1'b0;
      s_ERR = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         adr[i] = '0; datw[i] = '0; sel[i] = '0; we[i] = 1'b0;
         cti[i] = '0; bte[i] = '0; cyc[i] = 1'b0; stb[i] = 1'b0;
      end
      s_ACK = 1'b0;
      s_ERR = 1'b0;
      s_DAT_R = '0;
      do_reset();

      // Reset state and single write from master 0
      chk("reset_gnt", gnt, 2'b00);
      chk("reset_s_cyc", s_CYC, 1'b0);
      adr[0] = 32'h10; datw[0] = 32'hA5A5_A5A5; sel[0] = 4'hF; we[0] = 1'b1;
      cyc[0] = 1'b1; stb[0] = 1'b1;
      settle();
      chk("pre_grant_gnt", gnt, 2'b00);
      tick();
      chk("wr_gnt", gnt, 2'b01);
      chk("wr_s_adr", s_ADR, 32'h10);
      chk("wr_s_dat", s_DAT_W, 32'hA5A5_A5A5);
      chk("wr_s_stb", s_STB, 1'b1);
      tick();
      s_ACK = 1'b1;
      settle();
      chk("wr_ack", m_ACK, 2'b01);
      tick();
      s_ACK = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
      settle();
      chk("wr_ack_gone", m_ACK, 2'b00);
      tick();
      chk("wr_release", gnt, 2'b00);

      // Round-robin alternation with both masters always requesting
      do_reset();
      cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
      adr[1] = 32'h20;
      tick();
      for (int r = 0; r < 4; r++) begin
         logic [1:0] eg;
         eg = (r % 2 == 1) ? 2'b10 : 2'b01;
         chk("rr_order", gnt, eg);
         s_ACK = 1'b1;
         tick();
         s_ACK = 1'b0;
         chk("rr_hold", gnt, eg);
         cyc[r % 2] = 1'b0; stb[r % 2] = 1'b0;
         tick();
         cyc[r % 2] = 1'b1; stb[r % 2] = 1'b1;
      end

      // Master 1 burst holds the bus while master 0 waits
      idle_all();
      tick();
      tick();
      cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h100; cti[1] = 3'b010; bte[1] = 2'b00;
      tick();
      chk("burst_gnt", gnt, 2'b10);
      cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h200;
      for (int b = 0; b < 4; b++) begin
         adr[1] = 32'h100 + 32'(4 * b);
         cti[1] = (b == 3) ? 3'b111 : 3'b010;
         s_ACK = 1'b1;
         settle();
         chk("burst_owner", gnt, 2'b10);
         chk("burst_adr", s_ADR, 32'h100 + 32'(4 * b));
         chk("burst_cti", s_CTI, (b == 3) ? 3'b111 : 3'b010);
         chk("burst_ack", m_ACK, 2'b10);
         tick();
      end
      s_ACK = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
      tick();
      chk("handover_gnt", gnt, 2'b01);
      chk("handover_adr", s_ADR, 32'h200);

      // Slave error on a read reaches only the owner
      cyc[1] = 1'b1; stb[1] = 1'b1; we[0] = 1'b0;
      s_DAT_R = 32'hDEAD_BEEF; s_ERR = 1'b1;
      settle();
      chk("err_dat_r", m_DAT_R, 32'hDEAD_BEEF);
      chk("err_owner_only", m_ERR, 2'b01);
      chk("err_no_ack", m_ACK, 2'b00);
      tick();
      s_ERR = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
      // Watchdog abort after TMO stalled cycles, then ACK on the last allowed cycle
      idle_all();
      tick();
      tick();
      cyc[0] = 1'b1; stb[0] = 1'b1;
      tick();
      for (int t = 1; t <= int'(TMO); t++) begin
         chk("wd_wait_err", m_ERR, 2'b00);
         chk("wd_wait_cyc", s_CYC, 1'b1);
         tick();
      end
      chk("wd_err", m_ERR, 2'b01);
      chk("wd_cyc_off", s_CYC, 1'b0);
      chk("wd_stb_off", s_STB, 1'b0);
      tick();
      chk("wd_resume_cyc", s_CYC, 1'b1);
      chk("wd_resume_err", m_ERR, 2'b00);
      for (int t = 1; t < int'(TMO); t++) tick();
      s_ACK = 1'b1;
      settle();
      chk("wd_ack_wins", m_ACK, 2'b01);
      chk("wd_ack_no_err", m_ERR, 2'b00);
      tick();
      s_ACK = 1'b0;
      settle();
      chk("wd_no_abort_err", m_ERR, 2'b00);
      chk("wd_no_abort_cyc", s_CYC, 1'b1);
`endif

      // Asynchronous reset in the middle of a burst
      cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
      cti[0] = 3'b010; cti[1] = 3'b010;
      tick();
      tick();
      rst = 1'b1;
      settle();
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_s_cyc", s_CYC, 1'b0);
      chk("rst_s_stb", s_STB, 1'b0);
      chk("rst_s_adr", s_ADR, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      chk("rst_first_winner", gnt, 2'b01);

      // Randomized traffic: busy slave phase, then a slow slave phase to stress the watchdog
      for (int c = 0; c < 4000; c++) begin
         bit slow;
         slow = (c >= 2000);
         for (int i = 0; i < N; i++) begin
            if (!cyc[i]) cyc[i] = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, slow ? 39 : 5) == 0) cyc[i] = 1'b0;
            stb[i]  = ($urandom_range(0, slow ? 15 : 3) != 0);
            adr[i]  = $urandom;
            datw[i] = $urandom;
            sel[i]  = 4'($urandom);
            we[i]   = 1'($urandom);
            cti[i]  = 3'($urandom);
            bte[i]  = 2'($urandom);
         end
         s_ACK   = ($urandom_range(0, slow ? 15 : 3) == 0);
         s_ERR   = ($urandom_range(0, slow ? 63 : 15) == 0);
         s_DAT_R = $urandom;
         rst     = ($urandom_range(0, 499) == 0);
         tick();
      end
      rst = 1'b0;
      idle_all();
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_w.md
# wb_arbiter_w

Round-robin Wishbone arbiter that shares one slave port among `NUM_MASTERS` wire-level masters. It sits in front of the peripheral subsystem's slave port so that a CPU and a DMA engine can both reach the UART and other peripherals. Ownership is held for a whole `CYC` cycle, so burst transfers are never split. An optional watchdog terminates stalled transfers with `ERR`.

## Interface
Parameters:
- `NUM_MASTERS`, default 2: number of requesters; legal range 1..8.
- `WB_ADDR_WIDTH`, default 32: address width.
- `WB_DATA_WIDTH`, default 32: data width; `SEL` is `WB_DATA_WIDTH/8` bits wide.
- `TIMEOUT_CYCLES`, default 255: watchdog limit in cycles; legal range 1..65535.

Ports (N = `NUM_MASTERS`, AW = `WB_ADDR_WIDTH`, DW = `WB_DATA_WIDTH`, SW = DW/8). Each `m_*` vector is flattened; master i occupies slice i.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m_ADR`  in  N*AW  master addresses.
- `m_DAT_W`  in  N*DW  master write data.
- `m_SEL`  in  N*SW  master byte selects.
- `m_WE`  in  N  master write enables.
- `m_CTI`  in  N*3  master cycle type identifiers.
- `m_BTE`  in  N*2  master burst type extensions.
- `m_CYC`  in  N  master bus requests.
- `m_STB`  in  N  master strobes.
- `m_DAT_R`  out  DW  read data, broadcast to all masters.
- `m_ACK`  out  N  acknowledge, routed to the owner only.
- `m_ERR`  out  N  error, routed to the owner only.
- `s_ADR`, `s_DAT_W`, `s_SEL`, `s_WE`, `s_CTI`, `s_BTE`, `s_CYC`, `s_STB`  out  AW/DW/SW/1/3/2/1/1  owner's signals presented to the slave.
- `s_DAT_R`  in  DW  slave read data.
- `s_ACK`  in  1  slave acknowledge.
- `s_ERR`  in  1  slave error.
- `gnt`  out  N  one-hot current owner; all zeros when idle.

## Operation
- States:
  - `IDLE`: no owner.
  - `OWN`: `gnt` is one-hot.
  - `TERM`: watchdog abort; exists only with the watchdog compiled in.
- Arbitration is evaluated at each rising edge when the state is `IDLE`, or when the state is `OWN` and `m_CYC[owner]` is 0.
- The new owner is the first set `m_CYC` bit found scanning `last+1, last+2, …, last` (mod N). `last` is updated to the new owner.
- If no request is present, go to `IDLE` and clear `gnt`.
- `OWN`: the `s_*` outputs are a combinational mux of the owner's signals. `s_CYC = m_CYC[owner]`, `s_STB = m_STB[owner] & m_CYC[owner]`.
- `m_ACK[owner] = s_ACK` and `m_ERR[owner] = s_ERR`. Every other master receives 0 on `ACK` and `ERR`.
- With no owner, all `s_*` outputs are 0. `s_ACK` and `s_ERR` are ignored.
- `m_DAT_R = s_DAT_R` at all times.
- When `NUM_MASTERS` = 1, the block degenerates to a registered-grant pass-through.

## Timing
- Reset values: `gnt` = 0, state = `IDLE`, `last` = N-1 (master 0 wins first), every `s_*` output = 0, every `m_ACK`/`m_ERR` = 0, watchdog counter = 0.
- Grant latency: a request sampled at edge k sets `gnt` after edge k. `s_CYC` and `s_STB` appear in the cycle following edge k.
- Handover: the owner drops `CYC` before edge k; a waiting master is granted at edge k. There is exactly 0 idle cycles between owners.
- Simultaneous requests: resolved purely by round-robin order. A master that has just released ownership has the lowest priority at its next arbitration.
- A non-owner asserting `STB` is stalled; it sees no `ACK` until it is granted.
- `rst` asserted mid-transfer: `s_CYC`, `s_STB` and `gnt` drop asynchronously and the transfer is lost. No `ACK` is generated.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter increments each cycle that `s_CYC & s_STB & !s_ACK & !s_ERR` holds.
  - The counter clears on `ACK`, on `ERR`, on an owner change, or on any cycle where `s_STB` is 0.
  - When the counter reaches `TIMEOUT_CYCLES`, the next state is `TERM`. For exactly one cycle: `m_ERR[owner]` = 1, `s_CYC` = `s_STB` = 0, and the counter clears.
  - `TERM` then returns to the arbitration rule: the owner keeps the bus if its `CYC` is still high.
  - If `s_ACK` arrives in the same cycle the counter hits the limit, `ACK` wins and no `ERR` is generated.
- `WB_ARB_TIMEOUT_EN` undefined: no counter and no `TERM` state. `m_ERR` is sourced only from `s_ERR`.

## Test plan
- Reset, then master 0 single write (`ADR`=0x10, `DAT_W`=0xA5A5A5A5), slave acks 2 cycles later → `gnt`=01 one cycle after `CYC`; `s_ADR`=0x10; `m_ACK`=01 for one cycle.
- Both masters assert `CYC` in the same cycle, 4 rounds of one transfer each → grant order 0,1,0,1; a second `CYC` is never granted mid-transfer.
- Master 1 runs a 4-beat incrementing burst (`CTI`=010…111) while master 0 requests → master 1 holds all 4 beats; master 0 is granted on the edge where master 1 drops `CYC`.
- Slave read returns 0xDEADBEEF with `s_ERR` → `m_ERR` reaches only the owner; the non-owner's `m_ACK` and `m_ERR` stay 0.
- With `WB_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, the slave never acks → `m_ERR[owner]` pulses after 8 stalled cycles; `s_CYC` is 0 for that cycle. A repeat with `ACK` at cycle 8 → no `ERR`.
- Assert `rst` mid-burst → all `s_*` outputs and `gnt` go to 0 immediately. After release, master 0 wins the first arbitration.
